// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding,
// operation codes and the bit-counter width helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The counter must be able to hold every bit index 0..width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_addsub_add1b.sv
// add1b: single-bit full adder cell, reused as the per-bit engine of serial_addsub.
module add1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic r,
  output logic co
);

  assign r  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial A+B / A-B with start/busy/done handshake.
// Optional ov/zero flag outputs are built when SERIAL_ADDSUB_FLAGS_EN is defined.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
`ifdef SERIAL_ADDSUB_FLAGS_EN
  output logic             co,
  output logic             ov,
  output logic             zero
`else
  output logic             co
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q, sum_next;
  logic [CW-1:0]    cnt_q;
  logic             op_q, carry_q;
  logic             accept, last_bit;
  logic             cell_b, cell_r, cell_co;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (cnt_q == CW'(WIDTH - 1)) begin
        last_bit = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: invert B here, the +1 is the initial carry.
  assign cell_b = b_sh[0] ^ (op_q == OP_SUB);

  add1b u_cell (
    .a  (a_sh[0]),
    .b  (cell_b),
    .ci (carry_q),
    .r  (cell_r),
    .co (cell_co)
  );

  // Sum bits enter at the MSB and move right, so bit 0 lands last.
  always_comb begin
    sum_next            = sum_q >> 1;
    sum_next[WIDTH-1]   = cell_r;
  end

  // NOTE: working registers are reset too, so an aborted operation leaves no
  // residue in the operand, carry or counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      sum_q   <= '0;
      op_q    <= op;
      carry_q <= (op == OP_SUB);
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_q   <= sum_next;
      carry_q <= cell_co;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r    <= '0;
      co   <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
      ov   <= 1'b0;
      zero <= 1'b0;
`endif
    end else if (last_bit) begin
      r    <= sum_next;
      co   <= cell_co;
`ifdef SERIAL_ADDSUB_FLAGS_EN
      ov   <= carry_q ^ cell_co;
      zero <= ~|sum_next;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH = 8); flag checks are
// compiled in when SERIAL_ADDSUB_FLAGS_EN is defined.
module tb_serial_addsub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, co;
  logic [WIDTH-1:0] r;
`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic             ov, zero;
`endif

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] prev_r = '0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .r     (r),
`ifdef SERIAL_ADDSUB_FLAGS_EN
    .co    (co),
    .ov    (ov),
    .zero  (zero)
`else
    .co    (co)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, scramble inputs, measure latency/busy, check results.
  task automatic run_op(input string tag, input logic o, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] er,
                        input logic eco, input logic eov, input logic ez);
    int   edges;
    int   busy_cyc;
    logic seen;
    @(negedge clk);
    a = av; b = bv; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = ~o;
    check({tag, " r held during RUN"}, 32'(r), 32'(prev_r));
    edges    = 1;
    busy_cyc = busy ? 1 : 0;
    seen     = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
      else if (busy) busy_cyc++;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(WIDTH + 1));
    check({tag, " busy cycles"}, 32'(busy_cyc), 32'(WIDTH));
    check({tag, " r"}, 32'(r), 32'(er));
    check({tag, " co"}, 32'(co), 32'(eco));
`ifdef SERIAL_ADDSUB_FLAGS_EN
    check({tag, " ov"}, 32'(ov), 32'(eov));
    check({tag, " zero"}, 32'(zero), 32'(ez));
`else
    if (eov || ez) begin end
`endif
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " r held after done"}, 32'(r), 32'(er));
    prev_r = er;
  endtask

  initial begin
    int   edges;
    int   extra_done;
    logic seen;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset r", 32'(r), 32'd0);
    check("reset co", 32'(co), 32'd0);
`ifdef SERIAL_ADDSUB_FLAGS_EN
    check("reset ov", 32'(ov), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // Directed arithmetic vectors.
    run_op("add05_03", 1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0);
    run_op("addFF_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add7F_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("sub03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub05_05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);

    // start during RUN is ignored: 0xF0 + 0x22 = 0x112 -> r=0x12, co=1.
    @(negedge clk);
    a = 8'hF0; b = 8'h22; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; op = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    edges = 0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    check("ignore start done seen", 32'(seen), 32'd1);
    check("ignore start r", 32'(r), 32'h12);
    check("ignore start co", 32'(co), 32'd1);
    extra_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("ignore start single done", 32'(extra_done), 32'd0);
    check("ignore start idle", 32'(busy), 32'd0);

    // Asynchronous reset three edges into RUN.
    @(negedge clk);
    a = 8'h05; b = 8'h03; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst r", 32'(r), 32'd0);
    check("async rst co", 32'(co), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    extra_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("aborted op no done", 32'(extra_done), 32'd0);
    prev_r = '0;
    run_op("post_rst add01_01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
